// File: rtl/taxi_gt_cfg_pkg.sv
// rtl/taxi_gt_cfg_pkg.sv - shared types and helpers for the GT APB configuration sequencer
package taxi_gt_cfg_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_RMW   = 2'd1,
        OP_POLL  = 2'd2,
        OP_DELAY = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_SLV     = 2'd1,
        ERR_APB_TO  = 2'd2,
        ERR_POLL_TO = 2'd3
    } err_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_GAP,
        ST_DELAY,
        ST_RSP
    } state_t;

    // Width of the shared down-counter: must hold a delay count, the APB timeout and the poll gap.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/taxi_gt_apb_cfg_seq.sv
// rtl/taxi_gt_apb_cfg_seq.sv - command-driven APB master sequencing GT register accesses
module taxi_gt_apb_cfg_seq
    import taxi_gt_cfg_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int APB_TIMEOUT = 1024,
    parameter int POLL_MAX    = 256,
    parameter int POLL_GAP    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_cmd_valid,
    output logic                s_cmd_ready,
    input  logic [1:0]          s_cmd_op,
    input  logic [ADDR_W-1:0]   s_cmd_addr,
    input  logic [DATA_W-1:0]   s_cmd_data,
    input  logic [DATA_W-1:0]   s_cmd_mask,
    output logic                m_rsp_valid,
    input  logic                m_rsp_ready,
    output logic [DATA_W-1:0]   m_rsp_data,
    output logic [1:0]          m_rsp_err,
    output logic                busy,
    output logic [ADDR_W-1:0]   m_apb_paddr,
    output logic                m_apb_psel,
    output logic                m_apb_penable,
    output logic                m_apb_pwrite,
    output logic [DATA_W-1:0]   m_apb_pwdata,
    output logic [DATA_W/8-1:0] m_apb_pstrb,
    input  logic [DATA_W-1:0]   m_apb_prdata,
    input  logic                m_apb_pready,
    input  logic                m_apb_pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PCNT_W = $clog2(POLL_MAX + 1);
    localparam int CNT_W  = max3(DATA_W, $clog2(APB_TIMEOUT + 1), $clog2(POLL_GAP + 1));

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    err_t                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PCNT_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic                pwrite_q, pwrite_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;

    logic                poll_match;
    logic                poll_last;
    logic [DATA_W-1:0]   rmw_wdata;

    // A zero mask makes every read match, so mask=0 polls finish on the first read.
    assign poll_match = ((m_apb_prdata ^ data_q) & mask_q) == '0;
    assign poll_last  = poll_cnt_q >= PCNT_W'(POLL_MAX - 1);
    assign rmw_wdata  = (m_apb_prdata & ~mask_q) | (data_q & mask_q);

    // Next-state and registered-output computation; PSEL/PENABLE/valid default low each cycle.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        poll_cnt_d  = poll_cnt_q;
        data_d      = data_q;
        mask_d      = mask_q;
        pwdata_d    = pwdata_q;
        rsp_data_d  = rsp_data_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_cmd_valid) begin
                    op_d       = op_t'(s_cmd_op);
                    paddr_d    = s_cmd_addr;
                    data_d     = s_cmd_data;
                    mask_d     = s_cmd_mask;
                    poll_cnt_d = '0;
                    rsp_err_d  = ERR_OK;
                    rsp_data_d = '0;
                    if (op_t'(s_cmd_op) == OP_DELAY) begin
                        if (s_cmd_data == '0) begin
                            state_d     = ST_RSP;
                            rsp_valid_d = 1'b1;
                        end else begin
                            state_d = ST_DELAY;
                            cnt_d   = CNT_W'(s_cmd_data);
                        end
                    end else begin
                        state_d  = ST_SETUP;
                        psel_d   = 1'b1;
                        pwrite_d = (op_t'(s_cmd_op) == OP_WRITE);
                        pwdata_d = (op_t'(s_cmd_op) == OP_WRITE) ? s_cmd_data : '0;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                cnt_d     = CNT_W'(APB_TIMEOUT);
            end
            ST_ACCESS: begin
                if (m_apb_pready) begin
                    if (m_apb_pslverr) begin
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = ERR_SLV;
                        rsp_data_d  = m_apb_prdata;
                    end else if (pwrite_q) begin
                        // WRITE keeps 0, RMW keeps the original read value captured earlier.
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                    end else if (op_q == OP_RMW) begin
                        state_d    = ST_SETUP;
                        psel_d     = 1'b1;
                        pwrite_d   = 1'b1;
                        pwdata_d   = rmw_wdata;
                        rsp_data_d = m_apb_prdata;
                    end else begin
                        rsp_data_d = m_apb_prdata;
                        if (poll_cnt_q != PCNT_W'(POLL_MAX)) begin
                            poll_cnt_d = poll_cnt_q + PCNT_W'(1);
                        end
                        if (poll_match) begin
                            state_d     = ST_RSP;
                            rsp_valid_d = 1'b1;
                        end else if (poll_last) begin
                            state_d     = ST_RSP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = ERR_POLL_TO;
                        end else if (POLL_GAP == 0) begin
                            state_d = ST_SETUP;
                            psel_d  = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            cnt_d   = CNT_W'(POLL_GAP);
                        end
                    end
                end else if (cnt_q <= CNT_W'(1)) begin
                    // Abandon the transfer; any PREADY after this point lands outside ACCESS.
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_APB_TO;
                    rsp_data_d  = '0;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_SETUP;
                    psel_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DELAY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RSP: begin
                if (m_rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        pstrb_d     = {STRB_W{pwrite_d}};
    end

    // State and output registers; reset drops the APB handshake immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WRITE;
            rsp_err_q   <= ERR_OK;
            cnt_q       <= '0;
            poll_cnt_q  <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            pwdata_q    <= '0;
            rsp_data_q  <= '0;
            paddr_q     <= '0;
            pstrb_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            pwdata_q    <= pwdata_d;
            rsp_data_q  <= rsp_data_d;
            paddr_q     <= paddr_d;
            pstrb_q     <= pstrb_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign s_cmd_ready   = cmd_ready_q;
    assign m_rsp_valid   = rsp_valid_q;
    assign m_rsp_data    = rsp_data_q;
    assign m_rsp_err     = rsp_err_q;
    assign busy          = busy_q;
    assign m_apb_paddr   = paddr_q;
    assign m_apb_psel    = psel_q;
    assign m_apb_penable = penable_q;
    assign m_apb_pwrite  = pwrite_q;
    assign m_apb_pwdata  = pwdata_q;
    assign m_apb_pstrb   = pstrb_q;

endmodule
